// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: arbiter FSM state type, UART frame constants and the
// clocks-per-bit helper used to size baud-dependent counters.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } arb_state_t;

   // start + 8 data + stop
   localparam int unsigned FRAME_BITS = 10;

   // Watchdog span in bit times: one frame plus two bit times of slack.
   localparam int unsigned WDOG_FRAME_BITS = 12;

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud_rate);
      return clk_hz / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_i  [NUM_REQ-1:0] request vector
//   ptr_i  [PW-1:0]      index of the last owner; scan starts at ptr_i+1
//   gnt_o  [NUM_REQ-1:0] one-hot winner, 0 when no request
//   idx_o  [PW-1:0]      encoded winner
//   any_o                at least one request present
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      idx_o,
   output logic               any_o
);

   logic [PW-1:0] cand;

   // Walk ptr+1, ptr+2, ... with an explicit wrap so NUM_REQ need not be a
   // power of two; the first requester hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = ptr_i;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (cand == PW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer between NUM_REQ
// byte-stream requesters. One owner at a time; the grant is released at
// packet end, after MAX_BURST bytes, on a requester stall, or on watchdog
// expiry. All outputs are registered.
// Ports:
//   source_clk, rst      clock, synchronous active-high reset
//   req_valid/req_last   per-requester byte valid / end-of-packet
//   req_data             byte of requester i at [8i+7:8i]
//   req_ready            one-hot accept pulse (coincident with tx_valid)
//   grant                one-hot current owner, 0 when none
//   tx_valid/tx_message  to uart_tx; tx_message held until done
//   tx_active/tx_done    from uart_tx
//   busy                 grant held or frame in flight
//   timeout_err          one-cycle pulse on watchdog expiry
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned CLK_HZ    = 10_000_000
) (
   input  logic                 source_clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_valid,
   output logic [7:0]           tx_message,
   input  logic                 tx_active,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned PW       = $clog2(NUM_REQ);
   localparam int unsigned CPB      = clks_per_bit(CLK_HZ, BAUD_RATE);
   localparam int unsigned WD_LIMIT = WDOG_FRAME_BITS * CPB;
   localparam int unsigned WDW      = $clog2(WD_LIMIT + 1);
   localparam int unsigned BW       = $clog2(MAX_BURST + 1);

   arb_state_t         state_q,    state_d;
   logic [NUM_REQ-1:0] grant_q,    grant_d;
   logic [PW-1:0]      idx_q,      idx_d;
   logic [PW-1:0]      ptr_q,      ptr_d;
   logic [BW-1:0]      burst_q,    burst_d;
   logic [WDW-1:0]     wdog_q,     wdog_d;
   logic               last_q,     last_d;
   logic               tx_valid_q, tx_valid_d;
   logic [7:0]         tx_msg_q,   tx_msg_d;
   logic [NUM_REQ-1:0] ready_q,    ready_d;
   logic               busy_q,     busy_d;
   logic               tmo_q,      tmo_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [PW-1:0]      pick_idx;
   logic               pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      ptr_d      = ptr_q;
      burst_d    = burst_q;
      wdog_d     = wdog_q;
      last_d     = last_q;
      tx_valid_d = 1'b0;
      tx_msg_d   = tx_msg_q;
      ready_d    = '0;
      busy_d     = busy_q;
      tmo_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // tx_active gate also covers a frame left running across reset.
            if (pick_any && !tx_active) begin
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               burst_d = '0;
               busy_d  = 1'b1;
               state_d = SEND;
            end
         end

         SEND: begin
            if (req_valid[idx_q]) begin
               tx_valid_d = 1'b1;
               tx_msg_d   = req_data[{idx_q, 3'b000} +: 8];
               ready_d    = grant_q;
               last_d     = req_last[idx_q];
               burst_d    = burst_q + 1'b1;
               wdog_d     = '0;
               state_d    = WAIT;
            end else begin
               grant_d = '0;
               ptr_d   = idx_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         WAIT: begin
            if (tx_done) begin
               state_d = GAP;
            end else if (wdog_q == WDW'(WD_LIMIT - 1)) begin
               // Registered pulse lands exactly WD_LIMIT cycles after tx_valid.
               tmo_d   = 1'b1;
               grant_d = '0;
               ptr_d   = idx_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         GAP: begin
            if (!last_q && (burst_q < BW'(MAX_BURST))) begin
               state_d = SEND;
            end else begin
               grant_d = '0;
               ptr_d   = idx_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge source_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         idx_q      <= '0;
         ptr_q      <= PW'(NUM_REQ - 1);
         burst_q    <= '0;
         wdog_q     <= '0;
         last_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_msg_q   <= '0;
         ready_q    <= '0;
         busy_q     <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
         burst_q    <= burst_d;
         wdog_q     <= wdog_d;
         last_q     <= last_d;
         tx_valid_q <= tx_valid_d;
         tx_msg_q   <= tx_msg_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         tmo_q      <= tmo_d;
      end
   end

   assign req_ready   = ready_q;
   assign grant       = grant_q;
   assign tx_valid    = tx_valid_q;
   assign tx_message  = tx_msg_q;
   assign busy        = busy_q;
   assign timeout_err = tmo_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Each requester presents bytes with a valid/ready/last handshake. The arbiter grants one requester at a time and drives uart_tx's i_tx_valid/tx_message.
- It tracks the serializer's tx_active/done to pace frames, and releases the grant at packet end or after MAX_BURST bytes.
- Sits between the board's message sources (status, echo, debug) and uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum bytes sent per grant before forced rotation (1..255).
- BAUD_RATE, 9600, serializer baud rate; sizes the watchdog.
- CLK_HZ, 10_000_000, source_clk frequency; CLKS_PER_BIT = CLK_HZ/BAUD_RATE.

Ports:
- source_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte is last of packet
- req_ready  out  NUM_REQ  one-hot accept pulse; byte consumed when valid&ready
- grant  out  NUM_REQ  one-hot current owner, 0 when none
- tx_valid  out  1  to uart_tx i_tx_valid, single-cycle pulse
- tx_message  out  8  to uart_tx tx_message, held until done
- tx_active  in  1  from uart_tx
- tx_done  in  1  from uart_tx done (1-cycle pulse)
- busy  out  1  grant held or frame in flight
- timeout_err  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst=1 at clock edge) gives:
  - state=IDLE, grant=0, req_ready=0, tx_valid=0, tx_message=0, busy=0, timeout_err=0
  - rr pointer = NUM_REQ-1, so requester 0 has first priority
  - burst count = 0
- Reset mid-frame: the serializer has no reset and finishes its frame. The arbiter stays in IDLE until tx_active=0, so the frame is not corrupted.
- All outputs are registered.
- States: IDLE, SEND, WAIT, GAP.
- IDLE:
  - Condition: any req_valid and tx_active=0.
  - Pick the first valid index scanning ptr+1, ptr+2, … modulo NUM_REQ.
  - Register grant=onehot(g), burst=0, busy=1, then go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - If req_valid[g]=1: for one cycle, tx_valid=1, tx_message=req_data[g], req_ready[g]=1. Latch last=req_last[g], burst+=1, clear watchdog, go to WAIT.
  - If req_valid[g]=0: release the grant (grant=0, ptr=g, busy=0) and go to IDLE. A requester that stalls mid-packet loses the grant.
- WAIT:
  - Hold tx_message. Count cycles.
  - On tx_done=1, go to GAP.
  - If the count reaches 12*CLKS_PER_BIT without done: pulse timeout_err, release the grant (ptr=g), go to IDLE.
- GAP:
  - One guard cycle, covering the serializer's cleanup cycle; its i_tx_valid is only sampled when idle.
  - If last=0 and burst<MAX_BURST: go to SEND, keep the grant.
  - Else: grant=0, ptr=g, busy=0, go to IDLE.
- Pacing: consecutive bytes of one grant have tx_valid pulses exactly 10*CLKS_PER_BIT+3 cycles apart, given req_valid is held.
- A new requester needs at least 2 cycles from GAP (IDLE→SEND).
- tx_valid is never asserted while tx_active=1.
- At most one req_ready bit is high per cycle; it is only high in SEND coincident with tx_valid.
- Simultaneous requests: strict rotation. A requester that just released has the lowest priority next.
- req_last on a byte that also hits MAX_BURST releases once.
- Requester inputs changing while in WAIT/GAP are ignored.
- Widths:
  - burst is $clog2(MAX_BURST+1) bits.
  - watchdog is $clog2(12*CLKS_PER_BIT+1) bits.
  - ptr is $clog2(NUM_REQ) bits with explicit wrap at NUM_REQ-1→0; NUM_REQ need not be a power of 2.

Decomposition:
- Package uart_pkg:
  - state encodings: IDLE=2'd0, SEND=2'd1, WAIT=2'd2, GAP=2'd3
  - function clks_per_bit(CLK_HZ, BAUD_RATE)
  - frame length constant FRAME_BITS=10
- Sub-module rr_pick: combinational round-robin selector (req vector, ptr) → one-hot grant plus encoded index plus any-valid.
  - Instantiated once; verified standalone.

Test Plan:
Bench settings: CLK_HZ=10_000_000, BAUD_RATE=1_000_000 (CLKS_PER_BIT=10), uart_tx instantiated and monitored by a serial decoder.
- Single requester 0 sends 0x55, 0xA3 (last) → serial line carries 0x55 then 0xA3; tx_valid pulses 103 cycles apart; grant=0001 then 0000; busy falls 1 cycle after the second done.
- All 4 valid simultaneously, 1-byte packets 0x10..0x13 after reset → service order 0,1,2,3; grant one-hot each time; no tx_valid while tx_active=1.
- MAX_BURST=8: requester 1 streams 12 bytes without last while requester 2 waits → 8 bytes from 1, then requester 2's packet, then the remaining 4 from 1.
- Requester 3 drops req_valid after 2 of 5 bytes → grant released in SEND, ptr=3; requester 0 next gets the grant.
- Stub tx_done never pulses → timeout_err pulses once 120 cycles after tx_valid; arbiter back in IDLE with grant=0.
- Assert rst mid-frame (tx_active=1) with req_valid=0001 held → no tx_valid until tx_active=0; the following frame decodes correctly.
